// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher channels.
package pulse_stretcher_pkg;

    // Channel phase: waiting, driving the level, or enforcing recovery.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Width of a down-counter able to hold the larger of the two durations.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// One independent stretcher channel: FSM, down-counter, pending flag and
// registered level/drop outputs.
module stretcher_channel
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int GAP_CYCLES  = 100_000,
    parameter int RETRIGGER   = 1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pulse_in,
    output logic level_out,
    output logic drop_out
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    // A zero-length gap never loads the counter; keep the constant legal anyway.
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pending;

    // Channel FSM; level and drop are registered here so outputs never see
    // a combinational path from pulse_in.
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            level_out <= 1'b0;
            drop_out  <= 1'b0;
        end else begin
            drop_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pulse_in) begin
                        state     <= ST_HOLD;
                        cnt       <= HOLD_LOAD;
                        level_out <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (pulse_in && (RETRIGGER != 0)) begin
                        // Restart the hold, including on its final cycle.
                        cnt <= HOLD_LOAD;
                    end else begin
                        if (pulse_in) begin
                            drop_out <= 1'b1;
                        end
                        if (cnt == '0) begin
                            level_out <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state <= ST_GAP;
                                cnt   <= GAP_LOAD;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // Only one event can wait out the gap; later ones are lost.
                    if (pulse_in && pending) begin
                        drop_out <= 1'b1;
                    end
                    if (cnt == '0) begin
                        if (pending || pulse_in) begin
                            state     <= ST_HOLD;
                            cnt       <= HOLD_LOAD;
                            level_out <= 1'b1;
                            pending   <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (pulse_in && !pending) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    pending   <= 1'b0;
                    level_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Top: FIELDS independent stretcher channels plus parameter legality check.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int FIELDS      = 1,
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int GAP_CYCLES  = 100_000,
    parameter int RETRIGGER   = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [FIELDS-1:0] pulses_in,
    output logic [FIELDS-1:0] levels_out,
    output logic [FIELDS-1:0] drop_out
);

    // Reject parameter sets the channel cannot implement.
    if (FIELDS < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 0 ||
        (RETRIGGER != 0 && RETRIGGER != 1)) begin : g_param_check
        $error("pulse_stretcher: illegal parameters FIELDS=%0d HOLD_CYCLES=%0d GAP_CYCLES=%0d RETRIGGER=%0d",
               FIELDS, HOLD_CYCLES, GAP_CYCLES, RETRIGGER);
    end

    // One channel per field; channels share only clock and reset.
    for (genvar i = 0; i < FIELDS; i++) begin : g_field
        stretcher_channel #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .GAP_CYCLES  (GAP_CYCLES),
            .RETRIGGER   (RETRIGGER)
        ) u_channel (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .pulse_in  (pulses_in[i]),
            .level_out (levels_out[i]),
            .drop_out  (drop_out[i])
        );
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with three configurations:
// retriggering (a), non-retriggering (b) and three fields without gap (c).
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       pa, pb;
    logic [2:0] pc;
    logic       lvl_a, drp_a, lvl_b, drp_b;
    logic [2:0] lvl_c, drp_c;

    int total = 0;
    int bad   = 0;

    pulse_stretcher #(.FIELDS(1), .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1)) dut_a (
        .clk_in(clk), .rst_in(rst), .pulses_in(pa), .levels_out(lvl_a), .drop_out(drp_a));

    pulse_stretcher #(.FIELDS(1), .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0)) dut_b (
        .clk_in(clk), .rst_in(rst), .pulses_in(pb), .levels_out(lvl_b), .drop_out(drp_b));

    pulse_stretcher #(.FIELDS(3), .HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(1)) dut_c (
        .clk_in(clk), .rst_in(rst), .pulses_in(pc), .levels_out(lvl_c), .drop_out(drp_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs 14 edges on one DUT (sel 0=a, 1=b, 2=c). Bit e of p* is a pulse at
    // relative edge e; bit k of l*/d* is the expected value in cycle k.
    task automatic seq(input string tag, input int sel,
                       input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                       input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [2:0] ol, od;
        for (int e = 0; e < 14; e++) begin
            case (sel)
                0:       pa = p0[e];
                1:       pb = p0[e];
                default: pc = {p2[e], p1[e], p0[e]};
            endcase
            @(posedge clk);
            #1;
            pa = 1'b0;
            pb = 1'b0;
            pc = 3'b000;
            case (sel)
                0:       begin ol = {2'b00, lvl_a}; od = {2'b00, drp_a}; end
                1:       begin ol = {2'b00, lvl_b}; od = {2'b00, drp_b}; end
                default: begin ol = lvl_c;          od = drp_c;          end
            endcase
            check($sformatf("%s lvl c%0d", tag, e + 1), ol, {l2[e+1], l1[e+1], l0[e+1]});
            check($sformatf("%s drop c%0d", tag, e + 1), od, {d2[e+1], d1[e+1], d0[e+1]});
        end
    endtask

    initial begin
        pa  = 1'b0;
        pb  = 1'b0;
        pc  = 3'b000;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset lvl", {lvl_c[1:0] ^ 2'b00, lvl_a | lvl_b}, 3'b000);
        check("reset lvl c2", {2'b00, lvl_c[2]}, 3'b000);
        check("reset drop", {drp_c[1:0], drp_a | drp_b}, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single pulse: high cycles 1-4, gap 5-6.
        seq("single", 0, 'h1, 0, 0, 'h1E, 0, 0, 0, 0, 0);
        // Retrigger two edges later: high 1-6 without a dip.
        seq("retrig", 0, 'h5, 0, 0, 'h7E, 0, 0, 0, 0, 0);
        // Retrigger exactly on the last hold cycle: high 1-8.
        seq("retrig_end", 0, 'h11, 0, 0, 'h1FE, 0, 0, 0, 0, 0);
        // No retrigger: second pulse dropped, drop visible in cycle 3.
        seq("noretrig", 1, 'h5, 0, 0, 'h1E, 0, 0, 'h08, 0, 0);
        // No retrigger, pulse on last hold cycle dropped, hold ends on time.
        seq("noretrig_end", 1, 'h11, 0, 0, 'h1E, 0, 0, 'h20, 0, 0);
        // Pulses inside the gap: first pends, second dropped, rehold 7-10.
        seq("gap_pend", 0, 'h61, 0, 0, 'h79E, 0, 0, 'h80, 0, 0);
        // Pulse on last gap cycle with nothing pending: rehold 7-10, no drop.
        seq("gap_last", 0, 'h41, 0, 0, 'h79E, 0, 0, 0, 0, 0);
        // Three fields, no gap: field0 at 0 and 5, field2 at 1, field1 idle.
        seq("fields", 2, 'h21, 0, 'h2, 'h3DE, 0, 'h3C, 0, 0, 0);

        // Asynchronous reset in the middle of a hold.
        pa = 1'b1;
        @(posedge clk);
        #1 pa = 1'b0;
        check("prerst lvl c1", {2'b00, lvl_a}, 3'b001);
        @(posedge clk);
        #1;
        check("prerst lvl c2", {2'b00, lvl_a}, 3'b001);
        #2 rst = 1'b1;
        #1;
        check("async rst lvl", {2'b00, lvl_a}, 3'b000);
        check("async rst drop", {2'b00, drp_a}, 3'b000);
        pa = 1'b1;
        @(posedge clk);
        #1 pa = 1'b0;
        check("pulse in rst", {2'b00, lvl_a}, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post rst idle %0d", i), {2'b00, lvl_a}, 3'b000);
        end
        // A fresh pulse after release behaves like the first one.
        seq("rst_new", 0, 'h1, 0, 0, 'h1E, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
